// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI peripheral front-end.
package spi_pkg;

  localparam int SpiBits           = 8;
  localparam int SyncStagesDefault = 2;

  typedef enum logic {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus a history flop that
// turns level changes of the synchronized signal into single-cycle pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SyncStagesDefault,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      hist_q <= RESET_VALUE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_periph.sv
// SPI mode 0 peripheral front-end: oversamples SCK/CSN/SDI on clk_i,
// deserializes MOSI bytes and serializes the queued response byte on MISO.
module spi_periph
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SyncStagesDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               spi_sck_i,
  input  logic               spi_csn_i,
  input  logic               spi_sdi_i,
  output logic               spi_sdo_o,
  output logic [SpiBits-1:0] rx_data_o,
  output logic               rx_valid_o,
  input  logic [SpiBits-1:0] tx_data_i,
  input  logic               tx_valid_i
);

  localparam int CntW         = $clog2(SpiBits);
  localparam int SettleCycles = SYNC_STAGES + 1;

  logic sck_rise, sck_fall, csn_rise, csn_fall, sdi_level;
  logic sck_level_unused, csn_level_unused, sdi_rise_unused, sdi_fall_unused;

  spi_state_e         state_q, state_d;
  logic [2:0]         settle_q;
  logic               settled;
  logic [CntW-1:0]    bit_cnt_q;
  logic [SpiBits-1:0] rx_shift_q, tx_shift_q, rx_data_q, pend_data_q;
  logic [SpiBits-1:0] tx_load_value;
  logic               rx_valid_q, pend_q, load_next_q;
  logic               frame_start, frame_end, rx_step, tx_step;
  logic               tx_load, tx_shift, byte_done;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (spi_sck_i),
    .level_o(sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_csn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (spi_csn_i),
    .level_o(csn_level_unused),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sdi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (spi_sdi_i),
    .level_o(sdi_level),
    .rise_o (sdi_rise_unused),
    .fall_o (sdi_fall_unused)
  );

  // The csn synchronizer resets high, so a pin held low across reset would
  // show a fake csn_fall while the flops flush; edges are ignored until then.
  assign settled = (settle_q == 3'(SettleCycles));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settle_q <= '0;
    end else if (!settled) begin
      settle_q <= settle_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_step     = 1'b0;
    tx_step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (csn_fall && settled) begin
          state_d     = StActive;
          frame_start = 1'b1;
        end
      end
      StActive: begin
        if (csn_rise) begin
          state_d   = StIdle;
          frame_end = 1'b1;
        end else begin
          rx_step = sck_rise;
          tx_step = sck_fall;
        end
      end
    endcase
  end

  assign byte_done     = rx_step && (bit_cnt_q == CntW'(SpiBits - 1));
  assign tx_load       = frame_start || (tx_step && load_next_q);
  assign tx_shift      = tx_step && !load_next_q;
  assign tx_load_value = tx_valid_i ? tx_data_i : (pend_q ? pend_data_q : '0);

  // Pending buffer survives csn_rise so an aborted slot's response still
  // goes out at the start of the next frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      load_next_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (frame_end) begin
        bit_cnt_q   <= '0;
        rx_shift_q  <= '0;
        tx_shift_q  <= '0;
        load_next_q <= 1'b0;
      end
      if (rx_step) begin
        rx_shift_q <= {rx_shift_q[SpiBits-2:0], sdi_level};
        bit_cnt_q  <= bit_cnt_q + CntW'(1);
      end
      if (byte_done) begin
        rx_data_q   <= {rx_shift_q[SpiBits-2:0], sdi_level};
        rx_valid_q  <= 1'b1;
        load_next_q <= 1'b1;
      end
      if (tx_load) begin
        tx_shift_q  <= tx_load_value;
        pend_q      <= 1'b0;
        load_next_q <= 1'b0;
      end else begin
        if (tx_shift) begin
          tx_shift_q <= {tx_shift_q[SpiBits-2:0], 1'b0};
        end
        if (tx_valid_i) begin
          pend_q      <= 1'b1;
          pend_data_q <= tx_data_i;
        end
      end
    end
  end

  assign spi_sdo_o  = tx_shift_q[SpiBits-1];
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_periph.sv
// Self-checking bench for spi_periph: a bit-banged SPI host with directed
// boundary cases plus randomized frames checked against a slot-level model.
module tb_spi_periph;

  logic       clk_i = 1'b0;
  logic       rst_i, spi_sck_i, spi_csn_i, spi_sdi_i, spi_sdo_o;
  logic [7:0] rx_data_o, tx_data_i, tb_tx_data;
  logic       rx_valid_o, tx_valid_i, tb_tx_valid, loop_en;
  logic [7:0] rx_q[$];
  logic [7:0] got;
  int         total = 0;
  int         bad = 0;
  int         half = 8;

  assign tx_valid_i = loop_en ? rx_valid_o : tb_tx_valid;
  assign tx_data_i  = loop_en ? rx_data_o + 8'd1 : tb_tx_data;

  spi_periph #(.SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .spi_sck_i (spi_sck_i),
    .spi_csn_i (spi_csn_i),
    .spi_sdi_i (spi_sdi_i),
    .spi_sdo_o (spi_sdo_o),
    .rx_data_o (rx_data_o),
    .rx_valid_o(rx_valid_o),
    .tx_data_i (tx_data_i),
    .tx_valid_i(tx_valid_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (rx_valid_o) rx_q.push_back(rx_data_o);
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hostWrite(input logic [7:0] d);
    tb_tx_valid = 1'b1;
    tb_tx_data  = d;
    waitClk(1);
    tb_tx_valid = 1'b0;
  endtask

  task automatic frameBegin();
    spi_csn_i = 1'b0;
    waitClk(half);
  endtask

  task automatic frameEnd();
    waitClk(half);
    spi_csn_i = 1'b1;
    waitClk(2 * half);
  endtask

  task automatic partialBits(input logic [7:0] mosi, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_sdi_i = mosi[i];
      waitClk(half);
      spi_sck_i = 1'b1;
      waitClk(half);
      spi_sck_i = 1'b0;
    end
  endtask

  // One full byte slot; host writes land mid-slot, after this slot's load.
  task automatic applyStimulus(input logic [7:0] mosi, input int nw, input logic [7:0] w0,
                               input logic [7:0] w1, output logic [7:0] miso);
    miso = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_sdi_i = mosi[i];
      waitClk(half);
      miso[i]   = spi_sdo_o;
      spi_sck_i = 1'b1;
      waitClk(half);
      spi_sck_i = 1'b0;
      if (i == 4) begin
        if (nw > 0) hostWrite(w0);
        if (nw > 1) hostWrite(w1);
      end
    end
  endtask

  task automatic checkRx(input string tag, input logic [7:0] exp);
    checkOutput({tag, "_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) checkOutput({tag, "_data"}, rx_q[0], exp);
    rx_q.delete();
  endtask

  // Model: each slot carries the last write made during the previous slot of
  // the frame (0 if none); the first slot carries the last write made while
  // idle; writes during a frame's final slot are consumed by the trailing fall.
  task automatic randomFrames(input int nframes);
    logic [7:0] mosi[4], expm[4], w0[4], w1[4];
    int         nw[4];
    int         nb, nidle;
    logic [7:0] idle_val, miso;
    for (int f = 0; f < nframes; f++) begin
      half  = $urandom_range(5, 10);
      rx_q.delete();
      nidle = $urandom_range(0, 2);
      expm[0] = 8'h00;
      for (int j = 0; j < nidle; j++) begin
        idle_val = 8'($urandom);
        hostWrite(idle_val);
        expm[0] = idle_val;
      end
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        mosi[k] = 8'($urandom);
        nw[k]   = $urandom_range(0, 2);
        w0[k]   = 8'($urandom);
        w1[k]   = 8'($urandom);
        if (k + 1 < 4) expm[k+1] = (nw[k] == 0) ? 8'h00 : ((nw[k] == 1) ? w0[k] : w1[k]);
      end
      frameBegin();
      for (int k = 0; k < nb; k++) begin
        applyStimulus(mosi[k], nw[k], w0[k], w1[k], miso);
        checkOutput($sformatf("rnd%0d_miso%0d", f, k), miso, expm[k]);
      end
      frameEnd();
      checkOutput($sformatf("rnd%0d_rxcount", f), rx_q.size(), nb);
      for (int k = 0; k < nb && k < rx_q.size(); k++)
        checkOutput($sformatf("rnd%0d_rx%0d", f, k), rx_q[k], mosi[k]);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    spi_sck_i   = 1'b0;
    spi_csn_i   = 1'b1;
    spi_sdi_i   = 1'b0;
    tb_tx_valid = 1'b0;
    tb_tx_data  = 8'h00;
    loop_en     = 1'b0;
    waitClk(4);
    rst_i = 1'b0;
    waitClk(1);
    checkOutput("reset_sdo", spi_sdo_o, 0);
    checkOutput("reset_rx_valid", rx_valid_o, 0);
    checkOutput("reset_rx_data", rx_data_o, 8'h00);

    // Reset mid-frame with csn held low: must stay idle.
    frameBegin();
    partialBits(8'hF0, 4);
    rst_i = 1'b1;
    waitClk(2);
    rst_i = 1'b0;
    waitClk(4);
    rx_q.delete();
    checkOutput("rst_mid_rx_data", rx_data_o, 8'h00);
    applyStimulus(8'hFF, 0, 8'h00, 8'h00, got);
    checkOutput("rst_held_sdo", got, 8'h00);
    checkOutput("rst_held_no_rx", rx_q.size(), 0);
    frameEnd();
    frameBegin();
    applyStimulus(8'h5A, 0, 8'h00, 8'h00, got);
    frameEnd();
    checkOutput("after_rst_miso", got, 8'h00);
    checkRx("after_rst_rx", 8'h5A);

    frameBegin();
    applyStimulus(8'hA5, 0, 8'h00, 8'h00, got);
    frameEnd();
    checkOutput("a5_miso", got, 8'h00);
    checkRx("a5_rx", 8'hA5);

    loop_en = 1'b1;
    frameBegin();
    applyStimulus(8'h10, 0, 8'h00, 8'h00, got);
    checkOutput("loop_miso0", got, 8'h00);
    applyStimulus(8'h20, 0, 8'h00, 8'h00, got);
    checkOutput("loop_miso1", got, 8'h11);
    applyStimulus(8'h30, 0, 8'h00, 8'h00, got);
    checkOutput("loop_miso2", got, 8'h21);
    frameEnd();
    loop_en = 1'b0;
    checkOutput("loop_rxcount", rx_q.size(), 3);
    rx_q.delete();

    frameBegin();
    applyStimulus(8'h01, 2, 8'h3C, 8'hC3, got);
    checkOutput("lastwin_miso0", got, 8'h00);
    applyStimulus(8'h02, 0, 8'h00, 8'h00, got);
    checkOutput("lastwin_miso1", got, 8'hC3);
    applyStimulus(8'h03, 0, 8'h00, 8'h00, got);
    checkOutput("lastwin_miso2", got, 8'h00);
    frameEnd();
    rx_q.delete();

    partialBits(8'hA5, 8);
    checkOutput("csn_high_no_rx", rx_q.size(), 0);
    checkOutput("csn_high_sdo", spi_sdo_o, 0);

    // 7 bits, then the 8th sck_rise coincides with csn_rise.
    frameBegin();
    partialBits(8'hC7, 7);
    spi_sdi_i = 1'b1;
    waitClk(half);
    spi_sck_i = 1'b1;
    spi_csn_i = 1'b1;
    waitClk(half);
    spi_sck_i = 1'b0;
    waitClk(2 * half);
    checkOutput("csn_sck_same_no_rx", rx_q.size(), 0);
    checkOutput("csn_sck_same_sdo", spi_sdo_o, 0);
    frameBegin();
    applyStimulus(8'h3C, 0, 8'h00, 8'h00, got);
    frameEnd();
    checkRx("csn_sck_next_rx", 8'h3C);

    frameBegin();
    partialBits(8'hFF, 3);
    hostWrite(8'hD2);
    partialBits(8'hFF, 2);
    spi_csn_i = 1'b1;
    waitClk(2 * half);
    checkOutput("abort_no_rx", rx_q.size(), 0);
    checkOutput("abort_sdo", spi_sdo_o, 0);
    frameBegin();
    checkOutput("abort_pend_bit7", spi_sdo_o, 1);
    applyStimulus(8'h81, 0, 8'h00, 8'h00, got);
    frameEnd();
    checkOutput("abort_pend_miso", got, 8'hD2);
    checkRx("abort_next_rx", 8'h81);

    hostWrite(8'h7E);
    frameBegin();
    checkOutput("pend7e_bit7", spi_sdo_o, 0);
    applyStimulus(8'h00, 0, 8'h00, 8'h00, got);
    frameEnd();
    checkOutput("pend7e_miso", got, 8'h7E);
    rx_q.delete();

    randomFrames(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
